// File: rtl/reg_file_mp.sv
// Multi-port integer register file (NRD read / NWR write) with a hardwired-zero r0 and a busy scoreboard.
// Latency: reads are combinational; writes and busy updates take effect at the next rising clk edge.
// Backpressure: none. Every write and busy_set is accepted every cycle, and stalling on rbusy is the pipeline's job.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data and busy state to the read ports.

module reg_file_mp #(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int NRD     = 2,
  parameter int NWR     = 2,
  parameter int ZERO_R0 = 1,
  localparam int AW     = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NWR-1:0]       we,
  input  logic [NWR*AW-1:0]    waddr,
  input  logic [NWR*XLEN-1:0]  wdata,
  input  logic [NRD*AW-1:0]    raddr,
  output logic [NRD*XLEN-1:0]  rdata,
  input  logic                 busy_set,
  input  logic [AW-1:0]        busy_addr,
  output logic [NRD-1:0]       rbusy
);

  // Storage and scoreboard state
  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Per-register write resolution result for this cycle
  logic [NREG-1:0] wr_hit;
  logic [XLEN-1:0] wr_data [NREG];

  // Scratch read address used while walking the read ports
  logic [AW-1:0]   ra;

  // True when the address names a physically present register.
  // Addresses past NREG only exist when NREG is not a power of two.
  function automatic logic in_range(input logic [AW-1:0] a);
    return (32'(a) < NREG);
  endfunction

  // True when the address is r0 and r0 is hardwired to zero.
  function automatic logic is_hard_zero(input logic [AW-1:0] a);
    return (ZERO_R0 != 0) && (a == '0);
  endfunction

  // Resolve all write ports per register; later ports override earlier ones,
  // so the highest-index port wins on an address collision.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NREG; i++) begin
      wr_data[i] = '0;
    end
    for (int k = 0; k < NWR; k++) begin
      for (int i = 0; i < NREG; i++) begin
        if (we[k] && (waddr[k*AW +: AW] == AW'(i)) && !is_hard_zero(AW'(i))) begin
          wr_hit[i]  = 1'b1;
          wr_data[i] = wdata[k*XLEN +: XLEN];
        end
      end
    end
  end

  // Next-state data and scoreboard: a write clears busy, busy_set re-marks it,
  // and set beats clear when both land on the same register in one cycle.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = wr_hit[i] ? wr_data[i] : regs_q[i];
      if (wr_hit[i]) begin
        busy_d[i] = 1'b0;
      end
      if (busy_set && (busy_addr == AW'(i)) && !is_hard_zero(AW'(i))) begin
        busy_d[i] = 1'b1;
      end
    end
  end

  // State update; reset dominates any same-cycle write or busy_set
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q <= busy_d;
    end
  end

  // Combinational read ports; r0 (when hardwired) and absent registers read as
  // zero and never report busy, including under forwarding.
  always_comb begin
    rdata = '0;
    rbusy = '0;
    ra    = '0;
    for (int j = 0; j < NRD; j++) begin
      ra = raddr[j*AW +: AW];
      if (in_range(ra) && !is_hard_zero(ra)) begin
        rdata[j*XLEN +: XLEN] = regs_q[ra];
        rbusy[j]              = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
        // Forward the winning write port's data; the write's clear is
        // forwarded too, but a same-cycle busy_set still shows as busy.
        for (int k = 0; k < NWR; k++) begin
          if (we[k] && (waddr[k*AW +: AW] == ra)) begin
            rdata[j*XLEN +: XLEN] = wdata[k*XLEN +: XLEN];
            rbusy[j]              = busy_set && (busy_addr == ra);
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        we;
  logic [2*AW-1:0]   waddr;
  logic [2*XLEN-1:0] wdata;
  logic [2*AW-1:0]   raddr;
  logic              busy_set;
  logic [AW-1:0]     busy_addr;
  logic [2*XLEN-1:0] rdata_a, rdata_b;
  logic [1:0]        rbusy_a, rbusy_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Main configuration: 32 registers, hardwired r0
  reg_file_mp #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2), .ZERO_R0(1)) u_dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
    .rdata(rdata_a), .busy_set(busy_set), .busy_addr(busy_addr), .rbusy(rbusy_a)
  );

  // Non-power-of-two configuration with an ordinary r0, sharing all inputs
  reg_file_mp #(.XLEN(32), .NREG(20), .NRD(2), .NWR(2), .ZERO_R0(0)) u_odd (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
    .rdata(rdata_b), .busy_set(busy_set), .busy_addr(busy_addr), .rbusy(rbusy_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    we        = '0;
    waddr     = '0;
    wdata     = '0;
    busy_set  = 1'b0;
    busy_addr = '0;
  endtask

  task automatic wr(input int k, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    we[k]               = 1'b1;
    waddr[k*AW +: AW]   = a;
    wdata[k*XLEN +: XLEN] = d;
  endtask

  task automatic rd(input int j, input logic [AW-1:0] a);
    raddr[j*AW +: AW] = a;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr_in(); raddr = '0;
    tick(); tick();
    rst = 1'b0;
    rd(0, 5); rd(1, 6);
    #1;
    total++; if (rdata_a !== 64'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rdata_a); end
    total++; if (rbusy_a !== 2'b00) begin bad++; $display("FAIL reset_rbusy got=%b exp=00", rbusy_a); end
    // preload r5 and mark r6 busy
    wr(0, 5, 32'hDEADBEEF); busy_set = 1'b1; busy_addr = 6;
    tick(); clr_in(); #1;
    total++; if (rdata_a[31:0] !== 32'hDEADBEEF) begin bad++; $display("FAIL preload_r5 got=%h exp=deadbeef", rdata_a[31:0]); end
    total++; if (rbusy_a !== 2'b10) begin bad++; $display("FAIL preload_busy_r6 got=%b exp=10", rbusy_a); end
    rst = 1'b1;
    tick(); rst = 1'b0; #1;
    total++; if (rdata_a[31:0] !== 32'h0) begin bad++; $display("FAIL reset_clears_r5 got=%h exp=0", rdata_a[31:0]); end
    total++; if (rbusy_a !== 2'b00) begin bad++; $display("FAIL reset_clears_busy got=%b exp=00", rbusy_a); end
    total++; if (rbusy_b !== 2'b00) begin bad++; $display("FAIL reset_clears_busy_odd got=%b exp=00", rbusy_b); end
  endtask

  task automatic test_r0();
    rd(0, 0); rd(1, 0);
    wr(0, 0, 32'h1234); busy_set = 1'b1; busy_addr = 0;
    #1;
    total++; if (rdata_a !== 64'h0) begin bad++; $display("FAIL r0_same_cycle got=%h exp=0", rdata_a); end
    tick(); clr_in(); #1;
    total++; if (rdata_a[31:0] !== 32'h0) begin bad++; $display("FAIL r0_rdata got=%h exp=0", rdata_a[31:0]); end
    total++; if (rbusy_a !== 2'b00) begin bad++; $display("FAIL r0_rbusy got=%b exp=00", rbusy_a); end
    total++; if (rdata_b[31:0] !== 32'h1234) begin bad++; $display("FAIL r0_plain_rdata got=%h exp=1234", rdata_b[31:0]); end
    total++; if (rbusy_b !== 2'b11) begin bad++; $display("FAIL r0_plain_rbusy got=%b exp=11", rbusy_b); end
  endtask

  task automatic test_collision();
    wr(0, 7, 32'hAAAA); wr(1, 7, 32'h5555);
    tick(); clr_in(); rd(0, 7); rd(1, 7); #1;
    total++; if (rdata_a !== {32'h5555, 32'h5555}) begin bad++; $display("FAIL collision_r7 got=%h exp=5555 both", rdata_a); end
    total++; if (rdata_b[31:0] !== 32'h5555) begin bad++; $display("FAIL collision_r7_odd got=%h exp=5555", rdata_b[31:0]); end
    // distinct addresses on the two ports both land
    wr(0, 8, 32'h0808); wr(1, 10, 32'h1010);
    tick(); clr_in(); rd(0, 8); rd(1, 10); #1;
    total++; if (rdata_a !== {32'h1010, 32'h0808}) begin bad++; $display("FAIL dual_write got=%h exp=00001010_00000808", rdata_a); end
  endtask

  task automatic test_scoreboard();
    rd(0, 3); rd(1, 4);
    busy_set = 1'b1; busy_addr = 3;
    tick(); clr_in(); #1;
    total++; if (rbusy_a !== 2'b01) begin bad++; $display("FAIL busy_set_r3 got=%b exp=01", rbusy_a); end
    wr(1, 3, 32'h42);
    tick(); clr_in(); #1;
    total++; if (rbusy_a !== 2'b00) begin bad++; $display("FAIL busy_clear_r3 got=%b exp=00", rbusy_a); end
    total++; if (rdata_a[31:0] !== 32'h42) begin bad++; $display("FAIL write_r3 got=%h exp=42", rdata_a[31:0]); end
    wr(0, 3, 32'h43); busy_set = 1'b1; busy_addr = 3;
    tick(); clr_in(); #1;
    total++; if (rbusy_a !== 2'b01) begin bad++; $display("FAIL set_beats_clear got=%b exp=01", rbusy_a); end
    total++; if (rdata_a[31:0] !== 32'h43) begin bad++; $display("FAIL set_and_write_data got=%h exp=43", rdata_a[31:0]); end
  endtask

  task automatic test_bypass();
    rd(0, 9); rd(1, 0);
    wr(0, 9, 32'h11); busy_set = 1'b1; busy_addr = 9;
    tick(); clr_in(); #1;
    total++; if (rbusy_a[0] !== 1'b1) begin bad++; $display("FAIL bypass_pre_busy got=%b exp=1", rbusy_a[0]); end
    wr(1, 9, 32'h77); wr(0, 0, 32'hFFFF);
    #1;
`ifdef REGFILE_BYPASS_EN
    total++; if (rdata_a[31:0] !== 32'h77) begin bad++; $display("FAIL bypass_same_cycle got=%h exp=77", rdata_a[31:0]); end
    total++; if (rbusy_a[0] !== 1'b0) begin bad++; $display("FAIL bypass_busy_fwd got=%b exp=0", rbusy_a[0]); end
    total++; if (rdata_b[63:32] !== 32'hFFFF) begin bad++; $display("FAIL bypass_r0_plain got=%h exp=ffff", rdata_b[63:32]); end
`else
    total++; if (rdata_a[31:0] !== 32'h11) begin bad++; $display("FAIL nobypass_old got=%h exp=11", rdata_a[31:0]); end
    total++; if (rbusy_a[0] !== 1'b1) begin bad++; $display("FAIL nobypass_busy got=%b exp=1", rbusy_a[0]); end
    total++; if (rdata_b[63:32] !== 32'h1234) begin bad++; $display("FAIL nobypass_r0_plain got=%h exp=1234", rdata_b[63:32]); end
`endif
    total++; if (rdata_a[63:32] !== 32'h0) begin bad++; $display("FAIL bypass_r0_zero got=%h exp=0", rdata_a[63:32]); end
    tick(); clr_in(); #1;
    total++; if (rdata_a[31:0] !== 32'h77) begin bad++; $display("FAIL bypass_next_cycle got=%h exp=77", rdata_a[31:0]); end
    total++; if (rbusy_a[0] !== 1'b0) begin bad++; $display("FAIL bypass_next_busy got=%b exp=0", rbusy_a[0]); end
  endtask

  task automatic test_out_of_range();
    // address 21 exists in the 32-entry file but not the 20-entry one
    wr(0, 21, 32'hBAD); busy_set = 1'b1; busy_addr = 21;
    tick(); clr_in(); rd(0, 21); rd(1, 5); #1;
    total++; if (rdata_b[31:0] !== 32'h0) begin bad++; $display("FAIL oor_rdata got=%h exp=0", rdata_b[31:0]); end
    total++; if (rbusy_b !== 2'b00) begin bad++; $display("FAIL oor_rbusy_no_alias got=%b exp=00", rbusy_b); end
    total++; if (rdata_b[63:32] !== 32'h0) begin bad++; $display("FAIL oor_no_alias_r5 got=%h exp=0", rdata_b[63:32]); end
    total++; if (rdata_a[31:0] !== 32'hBAD) begin bad++; $display("FAIL r21_main got=%h exp=bad", rdata_a[31:0]); end
    total++; if (rbusy_a !== 2'b01) begin bad++; $display("FAIL r21_main_busy got=%b exp=01", rbusy_a); end
  endtask

  task automatic test_rst_write();
    rd(0, 4); rd(1, 21);
    rst = 1'b1; wr(0, 4, 32'h99); busy_set = 1'b1; busy_addr = 4;
    tick(); rst = 1'b0; clr_in(); #1;
    total++; if (rdata_a !== 64'h0) begin bad++; $display("FAIL rst_beats_write got=%h exp=0", rdata_a); end
    total++; if (rbusy_a !== 2'b00) begin bad++; $display("FAIL rst_beats_busy got=%b exp=00", rbusy_a); end
  endtask

  initial begin
    test_reset();
    test_r0();
    test_collision();
    test_scoreboard();
    test_bypass();
    test_out_of_range();
    test_rst_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
